// File: rtl/cruce_pkg.sv
// Shared definitions for the two-approach crossing controller: state codes,
// default phase timing and the per-state lamp decode.
package cruce_pkg;

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_A_GREEN  = 3'd1;
  localparam logic [2:0] ST_A_YELLOW = 3'd2;
  localparam logic [2:0] ST_ALLRED_A = 3'd3;
  localparam logic [2:0] ST_B_GREEN  = 3'd4;
  localparam logic [2:0] ST_B_YELLOW = 3'd5;
  localparam logic [2:0] ST_ALLRED_B = 3'd6;

  localparam int T_GREEN_DEF     = 40;
  localparam int T_MIN_GREEN_DEF = 10;
  localparam int T_YELLOW_DEF    = 10;
  localparam int T_ALLRED_DEF    = 5;
  localparam int TW_DEF          = 6;

  typedef struct packed {
    logic a_red;
    logic a_yellow;
    logic a_green;
    logic b_red;
    logic b_yellow;
    logic b_green;
    logic walk_a;
    logic walk_b;
  } lamps_t;

  // Pedestrians cross approach B while A has green, and vice versa.
  function automatic lamps_t decode_lamps(input logic [2:0] st);
    lamps_t l;
    l = '0;
    case (st)
      ST_A_GREEN:  begin l.a_green  = 1'b1; l.b_red = 1'b1; l.walk_b = 1'b1; end
      ST_A_YELLOW: begin l.a_yellow = 1'b1; l.b_red = 1'b1; end
      ST_ALLRED_A,
      ST_ALLRED_B: begin l.a_red    = 1'b1; l.b_red = 1'b1; end
      ST_B_GREEN:  begin l.b_green  = 1'b1; l.a_red = 1'b1; l.walk_a = 1'b1; end
      ST_B_YELLOW: begin l.b_yellow = 1'b1; l.a_red = 1'b1; end
      default:     l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/cruce_phase_timer.sv
// Cycles-in-phase counter: synchronous clear, saturates at all-ones.
module phase_timer #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic [TW-1:0] cnt_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)             cnt_d = '0;
    else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cruce_ctrl.sv
// Two-approach intersection sequencer with yellow/all-red clearance,
// pedestrian green shortening and emergency all-red preempt.
module cruce_ctrl
  import cruce_pkg::*;
#(
  parameter int T_GREEN     = T_GREEN_DEF,
  parameter int T_MIN_GREEN = T_MIN_GREEN_DEF,
  parameter int T_YELLOW    = T_YELLOW_DEF,
  parameter int T_ALLRED    = T_ALLRED_DEF,
  parameter int TW          = TW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  input  logic       preempt,
  output logic       a_red,
  output logic       a_yellow,
  output logic       a_green,
  output logic       b_red,
  output logic       b_yellow,
  output logic       b_green,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] state_out
);

  localparam logic [TW-1:0] GREEN_LAST  = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] MIN_LAST    = TW'(T_MIN_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(T_ALLRED - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer;
  logic          timer_clr;
  logic          ped_pend_a_q, ped_pend_a_d;
  logic          ped_pend_b_q, ped_pend_b_d;
  lamps_t        lamps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  // NOTE: defaulting state_d before the case keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:      state_d = ST_ALLRED_B;
        ST_A_GREEN:  if (preempt || timer == GREEN_LAST || (ped_pend_a_q && timer >= MIN_LAST))
                       state_d = ST_A_YELLOW;
        ST_A_YELLOW: if (timer == YELLOW_LAST) state_d = ST_ALLRED_A;
        ST_ALLRED_A: if (timer >= ALLRED_LAST && !preempt) state_d = ST_B_GREEN;
        ST_B_GREEN:  if (preempt || timer == GREEN_LAST || (ped_pend_b_q && timer >= MIN_LAST))
                       state_d = ST_B_YELLOW;
        ST_B_YELLOW: if (timer == YELLOW_LAST) state_d = ST_ALLRED_B;
        ST_ALLRED_B: if (timer >= ALLRED_LAST && !preempt) state_d = ST_A_GREEN;
        default:     state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    lamps     = decode_lamps(state_q);
    a_red     = lamps.a_red;
    a_yellow  = lamps.a_yellow;
    a_green   = lamps.a_green;
    b_red     = lamps.b_red;
    b_yellow  = lamps.b_yellow;
    b_green   = lamps.b_green;
    walk_a    = lamps.walk_a;
    walk_b    = lamps.walk_b;
    state_out = state_q;
  end

  // Timer restarts on every phase change and stays parked at zero while dark.
  assign timer_clr = (state_d != state_q) || (state_d == ST_OFF);

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (timer_clr),
    .cnt_o (timer)
  );

  // A request is served by the green that follows it; entering yellow retires it.
  always_comb begin
    ped_pend_a_d = ped_pend_a_q | (ped_req_a && state_q != ST_OFF);
    ped_pend_b_d = ped_pend_b_q | (ped_req_b && state_q != ST_OFF);
    if (!enable || (state_q == ST_A_GREEN && state_d == ST_A_YELLOW)) ped_pend_a_d = 1'b0;
    if (!enable || (state_q == ST_B_GREEN && state_d == ST_B_YELLOW)) ped_pend_b_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend_a_q <= 1'b0;
      ped_pend_b_q <= 1'b0;
    end else begin
      ped_pend_a_q <= ped_pend_a_d;
      ped_pend_b_q <= ped_pend_b_d;
    end
  end

endmodule

// File: tb/tb_cruce_ctrl.sv
// Bench for cruce_ctrl: phase-duration scoreboard plus per-cycle lamp and
// safety checks, driven through nominal, pedestrian, preempt, disable, reset and illegal-state cases.
module tb_cruce_ctrl;
  import cruce_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, enable, ped_req_a, ped_req_b, preempt;
  logic       a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk_a, walk_b;
  logic [2:0] state_out;
  logic [7:0] lamps;

  typedef struct {
    logic [2:0] st;
    int         len;
  } phase_t;

  phase_t     sb[$];
  phase_t     mon_e;
  logic [2:0] cur_state = 3'd0;
  int         run_len   = 0;
  int         checks    = 0;
  int         errors    = 0;

  cruce_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ped_req_a (ped_req_a),
    .ped_req_b (ped_req_b),
    .preempt   (preempt),
    .a_red     (a_red),
    .a_yellow  (a_yellow),
    .a_green   (a_green),
    .b_red     (b_red),
    .b_yellow  (b_yellow),
    .b_green   (b_green),
    .walk_a    (walk_a),
    .walk_b    (walk_b),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  assign lamps = {a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk_a, walk_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent lamp table: {a_r,a_y,a_g,b_r,b_y,b_g,walk_a,walk_b}.
  function automatic logic [7:0] exp_lamps(input logic [2:0] s);
    case (s)
      3'd1:       return 8'b001_100_01;
      3'd2:       return 8'b010_100_00;
      3'd3, 3'd6: return 8'b100_100_00;
      3'd4:       return 8'b100_001_10;
      3'd5:       return 8'b100_010_00;
      default:    return 8'b000_000_00;
    endcase
  endfunction

  // Monitor: per-cycle checks, and one scoreboard pop per completed phase.
  always @(negedge clk) begin
    check("safety", 32'((a_green | a_yellow) & (b_green | b_yellow)), 32'd0);
    check("lamps", lamps, exp_lamps(state_out));
    if (state_out != cur_state) begin
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("phase_state", cur_state, mon_e.st);
        check("phase_len", run_len, mon_e.len);
      end
      cur_state = state_out;
      run_len   = 1;
    end else begin
      run_len++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_phase(input logic [2:0] st, input int len);
    phase_t p;
    p.st  = st;
    p.len = len;
    sb.push_back(p);
  endtask

  task automatic wait_len(input logic [2:0] st, input int len);
    int n = 0;
    while (!(cur_state == st && run_len == len) && n < 400) begin
      step();
      n++;
    end
    if (!(cur_state == st && run_len == len)) check("wait_timeout", cur_state, st);
  endtask

  task automatic wait_enter(input logic [2:0] st);
    wait_len(st, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0; preempt = 1'b0;
    step(); step();
    check("rst_state", state_out, ST_OFF);
    check("rst_lamps", lamps, 8'd0);
    check("rst_timer", dut.timer, 0);
    check("rst_pend_a", dut.ped_pend_a_q, 0);
    check("rst_pend_b", dut.ped_pend_b_q, 0);

    // Nominal cycle, resuming through ALLRED_B.
    rst_n = 1'b1; enable = 1'b1;
    wait_enter(ST_ALLRED_B);
    expect_phase(ST_ALLRED_B, 5);  expect_phase(ST_A_GREEN, 40);
    expect_phase(ST_A_YELLOW, 10); expect_phase(ST_ALLRED_A, 5);
    expect_phase(ST_B_GREEN, 40);  expect_phase(ST_B_YELLOW, 10);
    expect_phase(ST_ALLRED_B, 5);
    drain();

    // Pedestrian pulse at A_GREEN timer=3 ends green at the minimum.
    wait_enter(ST_A_GREEN);
    expect_phase(ST_A_GREEN, 10);  expect_phase(ST_A_YELLOW, 10);
    expect_phase(ST_ALLRED_A, 5);  expect_phase(ST_B_GREEN, 40);
    expect_phase(ST_B_YELLOW, 10); expect_phase(ST_ALLRED_B, 5);
    wait_len(ST_A_GREEN, 4);
    ped_req_a = 1'b1; step(); ped_req_a = 1'b0;
    drain();

    // Pulse at timer=20 is seen at 21 and ends green there.
    wait_enter(ST_A_GREEN);
    expect_phase(ST_A_GREEN, 22); expect_phase(ST_A_YELLOW, 10);
    wait_len(ST_A_GREEN, 21);
    ped_req_a = 1'b1; step(); ped_req_a = 1'b0;

    // Request for B during A_YELLOW is held for the next B_GREEN.
    wait_enter(ST_A_YELLOW);
    expect_phase(ST_ALLRED_A, 5);  expect_phase(ST_B_GREEN, 10);
    expect_phase(ST_B_YELLOW, 10); expect_phase(ST_ALLRED_B, 5);
    wait_len(ST_A_YELLOW, 3);
    ped_req_b = 1'b1; step(); ped_req_b = 1'b0;
    wait_enter(ST_ALLRED_A);
    check("pend_b_held", dut.ped_pend_b_q, 1);
    wait_enter(ST_B_YELLOW);
    check("pend_b_cleared", dut.ped_pend_b_q, 0);
    drain();

    // Preempt from A_GREEN timer=5 for 20 edges.
    wait_enter(ST_A_GREEN);
    expect_phase(ST_A_GREEN, 6);  expect_phase(ST_A_YELLOW, 10);
    expect_phase(ST_ALLRED_A, 10); expect_phase(ST_B_GREEN, 40);
    wait_len(ST_A_GREEN, 6);
    preempt = 1'b1;
    repeat (20) step();
    preempt = 1'b0;
    drain();

    // Disable at A_YELLOW timer=4 with a pending request.
    wait_enter(ST_A_YELLOW);
    wait_len(ST_A_YELLOW, 4);
    ped_req_a = 1'b1; step();
    check("pend_a_in_yellow", dut.ped_pend_a_q, 1);
    enable = 1'b0; ped_req_a = 1'b0; step();
    check("dis_state", state_out, ST_OFF);
    check("dis_lamps", lamps, 8'd0);
    check("dis_timer", dut.timer, 0);
    check("dis_pend_a", dut.ped_pend_a_q, 0);
    expect_phase(ST_OFF, 3); expect_phase(ST_ALLRED_B, 5); expect_phase(ST_A_GREEN, 40);
    step(); step();
    enable = 1'b1;
    drain();

    // Asynchronous reset in the middle of B_GREEN.
    wait_enter(ST_B_GREEN);
    wait_len(ST_B_GREEN, 10);
    rst_n = 1'b0;
    #1;
    check("async_rst_state", state_out, ST_OFF);
    check("async_rst_lamps", lamps, 8'd0);
    step(); step();
    check("async_rst_timer", dut.timer, 0);
    rst_n = 1'b1;
    wait_enter(ST_ALLRED_B);
    expect_phase(ST_ALLRED_B, 5); expect_phase(ST_A_GREEN, 40);
    drain();

    // Illegal code 7 falls to OFF on the next edge, then restarts normally.
    expect_phase(ST_A_YELLOW, 1); expect_phase(ST_OFF, 1);
    expect_phase(ST_ALLRED_B, 5); expect_phase(ST_A_GREEN, 40);
    force dut.state_q = 3'd7;
    #1;
    check("illegal_state", state_out, 3'd7);
    check("illegal_lamps", lamps, 8'd0);
    #1;
    release dut.state_q;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
